// File: rtl/data_mem_responder.sv
// Memory-side responder for the core's req/gnt/rvalid interface: word-addressed
// storage with byte-enabled writes and in-order responses after a fixed latency.
module data_mem_responder #(
    parameter int unsigned             WORD_WIDTH      = 32,
    parameter int unsigned             DEPTH_WORDS     = 1024,
    parameter logic [WORD_WIDTH-1:0]   BASE_ADDR       = 32'h0000_0000,
    parameter int unsigned             RESP_LATENCY    = 1,
    parameter int unsigned             MAX_OUTSTANDING = 2,
    parameter bit                      GNT_STALL_EN    = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_i,
    input  logic [WORD_WIDTH-1:0] addr_i,
    input  logic                  we_i,
    input  logic [3:0]            be_i,
    input  logic [WORD_WIDTH-1:0] wdata_i,
    output logic                  gnt_o,
    output logic                  rvalid_o,
    output logic [WORD_WIDTH-1:0] rdata_o,
    output logic                  err_o
);

    localparam int unsigned IDX_W   = $clog2(DEPTH_WORDS);
    localparam int unsigned HI_W    = WORD_WIDTH - IDX_W - 2;
    localparam int unsigned LANE_W  = WORD_WIDTH / 4;
    localparam logic [2:0]  MAX_CNT = 3'(MAX_OUTSTANDING);

    // Fibonacci LFSR step, taps 8,6,5,4.
    function automatic logic [7:0] lfsr_next(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    logic [7:0]            lfsr_r;
    logic [2:0]            outstanding_r;
    logic [WORD_WIDTH-1:0] mem_r [DEPTH_WORDS];
    logic                  pipe_valid_r [RESP_LATENCY];
    logic                  pipe_err_r   [RESP_LATENCY];
    logic [WORD_WIDTH-1:0] pipe_data_r  [RESP_LATENCY];

    logic [WORD_WIDTH-1:0] offset_s;
    logic [IDX_W-1:0]      index_s;
    logic                  in_range_s;
    logic                  stall_s;
    logic                  room_s;
    logic                  accept_s;
    logic [WORD_WIDTH-1:0] resp_data_s;
    logic                  resp_err_s;
    logic                  addr_lsb_unused_s;

    // Address decode, grant and response payload for the current request.
    always_comb begin
        offset_s          = addr_i - BASE_ADDR;
        index_s           = offset_s[IDX_W+1:2];
        // Unsigned compare: offsets that wrapped below BASE_ADDR have high bits set.
        in_range_s        = (offset_s[WORD_WIDTH-1:IDX_W+2] == {HI_W{1'b0}});
        addr_lsb_unused_s = ^offset_s[1:0];
        stall_s           = GNT_STALL_EN && (lfsr_r[1:0] == 2'b00);
        // A response retiring this cycle frees its slot for a same-cycle grant.
        room_s            = (outstanding_r < MAX_CNT) || rvalid_o;
        gnt_o             = rst_n && req_i && room_s && !stall_s;
        accept_s          = gnt_o;
        resp_data_s       = {WORD_WIDTH{1'b0}};
        resp_err_s        = 1'b0;
        if (!accept_s) begin
            resp_data_s = {WORD_WIDTH{1'b0}};
            resp_err_s  = 1'b0;
        end else if (!in_range_s) begin
            resp_data_s = {WORD_WIDTH{1'b0}};
            resp_err_s  = 1'b1;
        end else if (we_i) begin
            resp_data_s = {WORD_WIDTH{1'b0}};
            resp_err_s  = 1'b0;
        end else begin
            resp_data_s = mem_r[index_s];
            resp_err_s  = 1'b0;
        end
    end

    // Storage update; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (accept_s && we_i && in_range_s) begin
            for (int n = 0; n < 4; n++) begin
                if (be_i[n]) begin
                    mem_r[index_s][n*LANE_W +: LANE_W] <= wdata_i[n*LANE_W +: LANE_W];
                end
            end
        end
    end

    // Grant-withholding LFSR, free running out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_r <= 8'hA5;
        end else begin
            lfsr_r <= lfsr_next(lfsr_r);
        end
    end

    // Accepted-but-unanswered transaction count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outstanding_r <= 3'd0;
        end else begin
            case ({accept_s, rvalid_o})
                2'b10:   outstanding_r <= outstanding_r + 3'd1;
                2'b01:   outstanding_r <= outstanding_r - 3'd1;
                default: outstanding_r <= outstanding_r;
            endcase
        end
    end

    // Response shift pipeline; the last stage drives the outputs directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(RESP_LATENCY); i++) begin
                pipe_valid_r[i] <= 1'b0;
                pipe_err_r[i]   <= 1'b0;
                pipe_data_r[i]  <= {WORD_WIDTH{1'b0}};
            end
        end else begin
            for (int i = int'(RESP_LATENCY) - 1; i > 0; i--) begin
                pipe_valid_r[i] <= pipe_valid_r[i-1];
                pipe_err_r[i]   <= pipe_err_r[i-1];
                pipe_data_r[i]  <= pipe_data_r[i-1];
            end
            pipe_valid_r[0] <= accept_s;
            pipe_err_r[0]   <= resp_err_s;
            pipe_data_r[0]  <= resp_data_s;
        end
    end

    assign rvalid_o = pipe_valid_r[RESP_LATENCY-1];
    assign err_o    = pipe_err_r[RESP_LATENCY-1];
    assign rdata_o  = pipe_data_r[RESP_LATENCY-1];

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: four instances with different
// latency / outstanding / stall settings share the address and data inputs.
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [3:0]  be;
    logic [3:0]  req;
    logic [3:0]  gnt;
    logic [3:0]  rv;
    logic [3:0]  er;
    logic [31:0] rd [4];
    logic [7:0]  m_lfsr;
    int          pass_cnt = 0;
    int          fail_cnt = 0;
    int          chk_cnt  = 0;

    always #5 clk = ~clk;

    data_mem_responder #(.RESP_LATENCY(1), .MAX_OUTSTANDING(2), .GNT_STALL_EN(1'b0)) u0 (
        .clk(clk), .rst_n(rst_n), .req_i(req[0]), .addr_i(addr), .we_i(we), .be_i(be),
        .wdata_i(wdata), .gnt_o(gnt[0]), .rvalid_o(rv[0]), .rdata_o(rd[0]), .err_o(er[0]));
    data_mem_responder #(.RESP_LATENCY(3), .MAX_OUTSTANDING(4), .GNT_STALL_EN(1'b0)) u1 (
        .clk(clk), .rst_n(rst_n), .req_i(req[1]), .addr_i(addr), .we_i(we), .be_i(be),
        .wdata_i(wdata), .gnt_o(gnt[1]), .rvalid_o(rv[1]), .rdata_o(rd[1]), .err_o(er[1]));
    data_mem_responder #(.RESP_LATENCY(4), .MAX_OUTSTANDING(2), .GNT_STALL_EN(1'b0)) u2 (
        .clk(clk), .rst_n(rst_n), .req_i(req[2]), .addr_i(addr), .we_i(we), .be_i(be),
        .wdata_i(wdata), .gnt_o(gnt[2]), .rvalid_o(rv[2]), .rdata_o(rd[2]), .err_o(er[2]));
    data_mem_responder #(.RESP_LATENCY(1), .MAX_OUTSTANDING(2), .GNT_STALL_EN(1'b1)) u3 (
        .clk(clk), .rst_n(rst_n), .req_i(req[3]), .addr_i(addr), .we_i(we), .be_i(be),
        .wdata_i(wdata), .gnt_o(gnt[3]), .rvalid_o(rv[3]), .rdata_o(rd[3]), .err_o(er[3]));

    // Reference LFSR: seed A5, taps 8,6,5,4, one step per clock out of reset.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_lfsr <= 8'hA5;
        else        m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt = chk_cnt + 1;
        assert (obs === exp) pass_cnt = pass_cnt + 1;
        else begin
            fail_cnt = fail_cnt + 1;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One isolated transaction on u0 (latency 1): grant same cycle, response next cycle.
    task automatic u0_access(input string tag, input logic w, input logic [31:0] a,
                             input logic [3:0] b, input logic [31:0] d,
                             input logic [31:0] exp_rd, input logic exp_er);
        @(posedge clk); #1;
        req[0] = 1'b1; we = w; addr = a; be = b; wdata = d;
        @(negedge clk);
        check({tag, " gnt"}, {31'd0, gnt[0]}, 32'd1);
        @(posedge clk); #1;
        req[0] = 1'b0;
        @(negedge clk);
        check({tag, " rvalid"}, {31'd0, rv[0]}, 32'd1);
        check({tag, " rdata"}, rd[0], exp_rd);
        check({tag, " err"}, {31'd0, er[0]}, {31'd0, exp_er});
    endtask

    initial begin
        logic [6:0] exp_gnt2;
        logic [6:0] exp_rv2;
        exp_gnt2 = 7'b0110011;
        exp_rv2  = 7'b0110000;
        rst_n = 1'b0; req = 4'b0001; we = 1'b0; addr = 32'd0; be = 4'd0; wdata = 32'd0;

        // Reset state, including grant suppressed while reset is held
        @(negedge clk);
        check("reset gnt", {31'd0, gnt[0]}, 32'd0);
        check("reset rvalid", {31'd0, rv[0]}, 32'd0);
        check("reset rdata", rd[0], 32'd0);
        check("reset err", {31'd0, er[0]}, 32'd0);
        req[0] = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Write then read, byte enables, no-op write, ignored low address bits
        u0_access("wr10", 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 32'd0, 1'b0);
        u0_access("rd10", 1'b0, 32'h10, 4'hF, 32'd0, 32'hDEADBEEF, 1'b0);
        u0_access("wr20", 1'b1, 32'h20, 4'hF, 32'h11223344, 32'd0, 1'b0);
        u0_access("wr20be", 1'b1, 32'h20, 4'b0101, 32'hAABBCCDD, 32'd0, 1'b0);
        u0_access("rd20be", 1'b0, 32'h20, 4'hF, 32'd0, 32'h11BB33DD, 1'b0);
        u0_access("wr20be0", 1'b1, 32'h20, 4'h0, 32'hFFFFFFFF, 32'd0, 1'b0);
        u0_access("rd20be0", 1'b0, 32'h20, 4'hF, 32'd0, 32'h11BB33DD, 1'b0);
        u0_access("rd23", 1'b0, 32'h23, 4'hF, 32'd0, 32'h11BB33DD, 1'b0);

        // Last in-range word, out-of-range write/read, word 0 not aliased
        u0_access("wr0", 1'b1, 32'h0, 4'hF, 32'h12345678, 32'd0, 1'b0);
        u0_access("wrffc", 1'b1, 32'hFFC, 4'hF, 32'hCAFEF00D, 32'd0, 1'b0);
        u0_access("wr1000", 1'b1, 32'h1000, 4'hF, 32'h55, 32'd0, 1'b1);
        u0_access("rd1000", 1'b0, 32'h1000, 4'hF, 32'd0, 32'd0, 1'b1);
        u0_access("rd0", 1'b0, 32'h0, 4'hF, 32'd0, 32'h12345678, 1'b0);
        u0_access("rdffc", 1'b0, 32'hFFC, 4'hF, 32'd0, 32'hCAFEF00D, 1'b0);

        // Back-to-back write then read of the same word
        @(posedge clk); #1;
        req[0] = 1'b1; we = 1'b1; addr = 32'h30; be = 4'hF; wdata = 32'h0BADCAFE;
        @(posedge clk); #1;
        we = 1'b0;
        @(negedge clk);
        check("raw gnt", {31'd0, gnt[0]}, 32'd1);
        check("raw wr rvalid", {31'd0, rv[0]}, 32'd1);
        check("raw wr rdata", rd[0], 32'd0);
        @(posedge clk); #1;
        req[0] = 1'b0;
        @(negedge clk);
        check("raw rd rvalid", {31'd0, rv[0]}, 32'd1);
        check("raw rd rdata", rd[0], 32'h0BADCAFE);
        @(negedge clk);
        check("idle rvalid", {31'd0, rv[0]}, 32'd0);
        check("idle rdata", rd[0], 32'd0);

        // Latency 3: preload three words, then three back-to-back reads
        @(posedge clk); #1;
        req[1] = 1'b1; we = 1'b1; be = 4'hF; addr = 32'h0; wdata = 32'hA0A0A0A0;
        @(posedge clk); #1;
        addr = 32'h4; wdata = 32'hB1B1B1B1;
        @(posedge clk); #1;
        addr = 32'h8; wdata = 32'hC2C2C2C2;
        @(posedge clk); #1;
        req[1] = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        req[1] = 1'b1; we = 1'b0; addr = 32'h0;
        @(negedge clk);
        check("lat3 gnt0", {31'd0, gnt[1]}, 32'd1);
        @(posedge clk); #1;
        addr = 32'h4;
        @(negedge clk);
        check("lat3 gnt1", {31'd0, gnt[1]}, 32'd1);
        check("lat3 early rv1", {31'd0, rv[1]}, 32'd0);
        @(posedge clk); #1;
        addr = 32'h8;
        @(negedge clk);
        check("lat3 gnt2", {31'd0, gnt[1]}, 32'd1);
        check("lat3 early rv2", {31'd0, rv[1]}, 32'd0);
        @(posedge clk); #1;
        req[1] = 1'b0;
        @(negedge clk);
        check("lat3 rv a", {31'd0, rv[1]}, 32'd1);
        check("lat3 rd a", rd[1], 32'hA0A0A0A0);
        check("lat3 err a", {31'd0, er[1]}, 32'd0);
        @(negedge clk);
        check("lat3 rv b", {31'd0, rv[1]}, 32'd1);
        check("lat3 rd b", rd[1], 32'hB1B1B1B1);
        @(negedge clk);
        check("lat3 rv c", {31'd0, rv[1]}, 32'd1);
        check("lat3 rd c", rd[1], 32'hC2C2C2C2);
        @(negedge clk);
        check("lat3 rv end", {31'd0, rv[1]}, 32'd0);
        check("lat3 rd end", rd[1], 32'd0);

        // Latency 4, two outstanding: held request is throttled, then reset with two in flight
        @(posedge clk); #1;
        req[2] = 1'b1; we = 1'b1; addr = 32'h40; be = 4'hF; wdata = 32'h600DF00D;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            check($sformatf("lim gnt c%0d", c), {31'd0, gnt[2]}, {31'd0, exp_gnt2[c]});
            check($sformatf("lim rv c%0d", c), {31'd0, rv[2]}, {31'd0, exp_rv2[c]});
        end
        #1;
        rst_n = 1'b0;
        req[2] = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check($sformatf("rst drop rv c%0d", c), {31'd0, rv[2]}, 32'd0);
            check($sformatf("rst drop rd c%0d", c), rd[2], 32'd0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Stall: grant withheld exactly when the seed-A5 LFSR low bits are 00
        req[3] = 1'b1; we = 1'b1; addr = 32'h80; be = 4'hF; wdata = 32'h77;
        for (int c = 0; c < 64; c++) begin
            @(negedge clk);
            check($sformatf("stall gnt c%0d", c), {31'd0, gnt[3]},
                  {31'd0, (m_lfsr[1:0] != 2'b00)});
        end
        @(posedge clk); #1;
        req[3] = 1'b0;

        // Write accepted before reset persists
        @(posedge clk); #1;
        req[2] = 1'b1; we = 1'b0; addr = 32'h40;
        @(negedge clk);
        check("persist gnt", {31'd0, gnt[2]}, 32'd1);
        @(posedge clk); #1;
        req[2] = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("persist wait c%0d", c), {31'd0, rv[2]}, 32'd0);
        end
        @(negedge clk);
        check("persist rv", {31'd0, rv[2]}, 32'd1);
        check("persist rd", rd[2], 32'h600DF00D);
        check("persist err", {31'd0, er[2]}, 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
